// File: rtl/sid_stream_recorder_pkg.sv
// sid_stream_recorder_pkg
// Shared definitions for the SID stream recorder, the ROM-driven player and
// the entry FIFO: stream constants, the recorder FSM state type and the
// 13-bit playback entry layout.
package sid_stream_recorder_pkg;

   // addr code that marks a delay entry in the playback stream
   localparam logic [4:0] DELAY_CMD = 5'h1f;
   // highest SID register that is recorded; writes above it are ignored
   localparam logic [4:0] MAX_REG   = 5'h1c;
   localparam int unsigned NUM_REGS = 29;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      EMIT_DELAY = 2'd1,
      EMIT_WRITE = 2'd2
   } rec_state_t;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } sid_entry_t;

endpackage

// File: rtl/sid_stream_recorder_if.sv
// sid_stream_recorder_if
// Valid/ready stream of playback entries leaving the recorder.
//   out_valid  entry available (recorder -> consumer)
//   out_addr   entry addr field: SID register or DELAY_CMD
//   out_data   entry data field: register value or delay count
//   out_ready  consumer accepts the entry when out_valid && out_ready
// Modports: master = recorder side, slave = FIFO / entry writer side.
interface sid_stream_recorder_if;

   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_addr;
   logic [7:0] out_data;

   modport master (output out_valid, output out_addr, output out_data, input out_ready);
   modport slave  (input out_valid, input out_addr, input out_data, output out_ready);

endinterface

// File: rtl/sid_stream_recorder_gap_counter.sv
// sid_gap_counter
// Counts idle SID cycles between recorded writes.
//   clk, reset  main clock, asynchronous active-high reset
//   inc         one idle SID cycle was accepted
//   clr         discard the count (write captured or recording disabled)
//   gap         current idle count, 9 bits
//   chunk_last  gap is 255: the next accepted idle cycle completes a
//               256-cycle chunk, which the owner flushes as a 0xFF delay
// The 256th idle cycle is the flush itself, so the count wraps straight to
// zero on that increment instead of lingering at 256.
module sid_gap_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [8:0] gap,
   output logic       chunk_last
);

   logic [8:0] gap_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_reg <= '0;
      end else if (clr) begin
         gap_reg <= '0;
      end else if (inc) begin
         if (gap_reg == 9'd255) begin
            gap_reg <= '0;
         end else begin
            gap_reg <= gap_reg + 9'd1;
         end
      end
   end

   assign gap        = gap_reg;
   assign chunk_last = (gap_reg == 9'd255);

endmodule

// File: rtl/sid_stream_recorder.sv
// sid_stream_recorder
// Snoops SID register writes and encodes them into the ROM playback stream:
// write entries (reg, value) and delay entries (DELAY_CMD, N) covering N+1
// SID cycles. Idle cycles accumulate in a gap counter; a write preceded by a
// gap emits the delay first while the write waits in a pending register.
//   clk, reset   main clock, asynchronous active-high reset
//   ce_1m        SID cycle enable; rec_en sampled only when it is high
//   we/addr/data_in  snooped SID write bus
//   stream       entry output (out_valid/out_addr/out_data/out_ready)
//   overflow     sticky: an event needing an emission arrived while busy
//   entry_count  accepted entries, saturating
// Optional macro SIDREC_DEDUP_EN: suppress writes repeating the value already
// recorded for that register; such writes count as idle cycles.
module sid_stream_recorder
   import sid_stream_recorder_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce_1m,
   input  logic                   rec_en,
   input  logic                   we,
   input  logic [4:0]             addr,
   input  logic [7:0]             data_in,
   sid_stream_recorder_if.master  stream,
   output logic                   overflow,
   output logic [COUNT_WIDTH-1:0] entry_count
);

   rec_state_t state_reg, state_next;

   logic [8:0]  gap;
   logic        chunk_last;
   logic        in_range, dup, sid_event, wr_event, idle_event, is_idle;
   logic        capture_wr, capture_flush, gap_inc, gap_clr, handshake;
   logic [7:0]  delay_val_reg;
   sid_entry_t  pending_reg;
   logic        pending_valid_reg;
   logic        overflow_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic        out_valid_c;
   sid_entry_t  out_entry_c;

   assign in_range   = (addr <= MAX_REG);
   assign sid_event  = ce_1m && rec_en;
   assign wr_event   = sid_event && we && in_range && !dup;
   assign idle_event = sid_event && !wr_event;
   assign is_idle    = (state_reg == IDLE);

   assign capture_wr    = wr_event && is_idle;
   assign capture_flush = idle_event && chunk_last && is_idle;
   // An idle cycle that would complete a chunk while busy is dropped with
   // the gap left as is; any other idle cycle counts even while busy.
   assign gap_inc   = idle_event && !(chunk_last && !is_idle);
   assign gap_clr   = (ce_1m && !rec_en) || capture_wr;
   assign handshake = out_valid_c && stream.out_ready;

`ifdef SIDREC_DEDUP_EN
   logic [7:0]          shadow_mem [0:NUM_REGS-1];
   logic [NUM_REGS-1:0] written_reg;

   // Shadow tracks what the stream has been told, so only captured writes
   // update it; dropped writes leave it untouched.
   always_ff @(posedge clk) begin
      if (capture_wr) begin
         shadow_mem[addr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         written_reg <= '0;
      end else if (capture_wr) begin
         written_reg[addr] <= 1'b1;
      end
   end

   assign dup = in_range && written_reg[addr] && (shadow_mem[addr] == data_in);
`else
   assign dup = 1'b0;
`endif

   sid_gap_counter u_gap (
      .clk        (clk),
      .reset      (reset),
      .inc        (gap_inc),
      .clr        (gap_clr),
      .gap        (gap),
      .chunk_last (chunk_last)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (capture_flush) begin
               state_next = EMIT_DELAY;
            end else if (capture_wr) begin
               state_next = (gap != 9'd0) ? EMIT_DELAY : EMIT_WRITE;
            end
         end
         EMIT_DELAY: begin
            if (stream.out_ready) begin
               state_next = pending_valid_reg ? EMIT_WRITE : IDLE;
            end
         end
         EMIT_WRITE: begin
            if (stream.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: a pure decode of the state register and of registers that
   // only load in IDLE, so the entry holds steady while stalled and drops
   // together with the state on reset.
   always_comb begin
      out_valid_c = 1'b0;
      out_entry_c = '0;
      case (state_reg)
         EMIT_DELAY: begin
            out_valid_c      = 1'b1;
            out_entry_c.addr = DELAY_CMD;
            out_entry_c.data = delay_val_reg;
         end
         EMIT_WRITE: begin
            out_valid_c = 1'b1;
            out_entry_c = pending_reg;
         end
         default: ;
      endcase
   end

   assign stream.out_valid = out_valid_c;
   assign stream.out_addr  = out_entry_c.addr;
   assign stream.out_data  = out_entry_c.data;

   // Entry payload, pending write, overflow and accepted-entry count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         delay_val_reg     <= '0;
         pending_reg       <= '0;
         pending_valid_reg <= 1'b0;
         overflow_reg      <= 1'b0;
         count_reg         <= '0;
      end else begin
         if (capture_flush) begin
            delay_val_reg <= 8'hff;
         end else if (capture_wr && (gap != 9'd0)) begin
            // gap is below 256 here: a full chunk is flushed on its own
            delay_val_reg <= gap[7:0] - 8'd1;
         end

         if (capture_wr) begin
            pending_reg.addr  <= addr;
            pending_reg.data  <= data_in;
            pending_valid_reg <= 1'b1;
         end else if ((state_reg == EMIT_WRITE) && stream.out_ready) begin
            pending_valid_reg <= 1'b0;
         end

         if ((wr_event || (idle_event && chunk_last)) && !is_idle) begin
            overflow_reg <= 1'b1;
         end

         if (handshake && (count_reg != {COUNT_WIDTH{1'b1}})) begin
            count_reg <= count_reg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   assign overflow    = overflow_reg;
   assign entry_count = count_reg;

endmodule

// File: doc/sid_stream_recorder.md
Name: sid_stream_recorder

Overview:
- Snoops the SID register-write bus (we/addr/data qualified by ce_1m) and encodes it into the ROM playback stream format: 5-bit addr plus 8-bit data entries.
- Idle SID cycles are encoded as delay entries (addr = DELAY_CMD) so the stream can be replayed by the ROM-driven SID player.
- Sits beside sid8580 on the main clock domain. Its output feeds a FIFO or an entry writer through a valid/ready handshake.

Parameters:
DELAY_CMD, 5'h1f, addr code marking a delay entry
MAX_REG, 5'h1c, highest SID register recorded; writes above it are ignored
COUNT_WIDTH, 16, width of entry_count

Ports:
clk  in  1  main clock (12 MHz)
reset  in  1  asynchronous, active-high reset
ce_1m  in  1  SID cycle enable, one clk pulse per SID cycle
rec_en  in  1  recording enable, sampled on ce_1m cycles only
we  in  1  snooped SID write enable
addr  in  5  snooped SID register address
data_in  in  8  snooped SID write data
out_valid  out  1  stream entry available
out_addr  out  5  entry addr field (register or DELAY_CMD)
out_data  out  8  entry data field (register value or delay count)
out_ready  in  1  consumer accepts entry when out_valid&&out_ready
overflow  out  1  sticky: an event was lost because the output was busy
entry_count  out  COUNT_WIDTH  number of entries accepted by the consumer, saturating

Behaviour:
- Reset (async, active-high): out_valid=0, out_addr=0, out_data=0, overflow=0, entry_count=0, gap=0, FSM=IDLE, pending write cleared.
- Entry semantics:
  - A write entry occupies exactly 1 SID cycle.
  - A delay entry with value N occupies N+1 SID cycles (its own slot plus N idle), N in 0..255.
- SID event: a clk where ce_1m=1 and rec_en=1. A write event additionally has we=1 and addr<=MAX_REG.
  - we=1 with addr>MAX_REG counts as an idle cycle; it is never emitted.
- Gap counter: 9 bits.
  - Increments on each non-write SID event.
  - Cleared when a write event is captured or when a 256-cycle chunk is flushed.
- Chunk flush: when gap reaches 256, emit delay entry out_data=8'hFF and set gap=0.
- Write event with gap G:
  - G>0: emit delay entry (DELAY_CMD, G-1), then write entry (addr, data_in).
  - G=0: emit the write entry only.
  - The write is held in the pending register while the delay entry drains.
- FSM:
  - IDLE -> EMIT_DELAY when a gap must be flushed or precede a write.
  - IDLE -> EMIT_WRITE on a write event with G=0.
  - EMIT_DELAY -> EMIT_WRITE on handshake if a write is pending, else -> IDLE.
  - EMIT_WRITE -> IDLE on handshake.
- Handshake:
  - out_valid is registered, asserted one clk after the event.
  - out_addr/out_data stay stable while out_valid && !out_ready.
  - Deassertion happens on the clk after the handshake.
- Overflow: a SID event arriving while FSM!=IDLE and the event needs an emission sets overflow. The event is dropped and gap is unchanged. The in-flight entry is unaffected.
- rec_en:
  - Low: SID events are ignored and gap is held at 0.
  - Falling: the partial gap is discarded; an in-flight emission completes.
  - Rising: counting starts at gap=0, so the first write is emitted without a delay.
- entry_count: increments on each handshake and saturates at all-ones.
- Reset mid-emission: the entry is abandoned and out_valid drops asynchronously.

Optional Feature:
- Macro: SIDREC_DEDUP_EN.
- Defined:
  - A 29x8 shadow of registers 0x00..0x1c plus a 29-bit written flag is kept.
  - A write event whose data equals the shadow value of an already-written register is treated as idle: it counts into gap and is not emitted.
  - The shadow updates only on emitted writes.
  - reset clears the written flags.
- Undefined: every write event is emitted; no shadow storage.

Decomposition:
- Shared package holds:
  - DELAY_CMD and the MAX_REG constant.
  - FSM state typedef (IDLE, EMIT_DELAY, EMIT_WRITE).
  - Entry struct {addr[4:0], data[7:0]}, reused by the ROM player and the FIFO.
- One sub-module, sid_gap_counter: the 9-bit gap count with 256-chunk flush request and clear.

Test Plan:
- Writes to reg 0x18=0x0F at SID cycle 0 and reg 0x04=0x11 at cycle 1, out_ready=1 -> entries (18,0F),(04,11); no delay; entry_count=2.
- Write 0x00=0x25 at cycle 0, write 0x01=0x1C at cycle 11 -> (00,25),(1F,09),(01,1C).
- Write at cycle 0, next write at cycle 600 -> (xx),(1F,FF),(1F,FF),(1F,56),(xx); 1+256+256+87 slots.
- Hold out_ready=0 for 30 clk during a delay, with a write at the next SID cycle -> entry stable, overflow=1, write dropped, gap intact.
- Write addr 0x1e, then 0x1f with rec_en toggled low for 5 cycles -> nothing emitted for 0x1e/0x1f; first write after rising rec_en has no delay entry.
- SIDREC_DEDUP_EN defined: write 0x05=0x09 twice, 3 cycles apart -> one write entry; repeat counts into next delay. Undefined: (05,09),(1F,01),(05,09).
